// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants and helpers for the instruction/data memory request arbiter.
//   - FSM state encodings, owner encodings, access size codes
//   - kseg segment prefixes and the fixed virtual-to-physical translation
package mem_req_arbiter_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;

  typedef struct packed {
    logic [BUS_W-1:0] addr;
    logic             uncache;
  } xlate_t;

  // kseg0 drops bit 31, kseg1 drops bits 31:29 and bypasses the cache,
  // every other segment is mapped 1:1.
  function automatic xlate_t xlate(input logic [BUS_W-1:0] vaddr);
    xlate_t r;
    r.addr    = vaddr;
    r.uncache = 1'b0;
    if (vaddr[31:29] == KSEG0) begin
      r.addr[31] = 1'b0;
    end else if (vaddr[31:29] == KSEG1) begin
      r.addr[31:29] = 3'b000;
      r.uncache     = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response bus used for both requesters and the downstream port.
//   req/wr/size/addr/wdata/uncache : request side, driven by the master
//   addr_ok/data_ok/rdata          : response side, driven by the slave
interface mem_req_arbiter_if;
  import mem_req_arbiter_pkg::*;

  logic             req;
  logic             wr;
  logic [1:0]       size;
  logic [BUS_W-1:0] addr;
  logic [BUS_W-1:0] wdata;
  logic             uncache;
  logic             addr_ok;
  logic             data_ok;
  logic [BUS_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata, uncache,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata, uncache,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/mem_req_arbiter_arb_pick.sv
// Combinational 2-way grant selector.
//   inst_req, data_req : pending requests
//   last_grant         : owner of the previous grant
//   gnt_valid          : some requester is granted
//   gnt_owner          : OWN_INST / OWN_DATA
// FAIR = 1 alternates on a tie, FAIR = 0 always favours data.
module arb_pick
  import mem_req_arbiter_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic inst_req,
  input  logic data_req,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_owner
);

  always_comb begin
    gnt_valid = inst_req | data_req;
    if (inst_req && data_req) begin
      gnt_owner = FAIR ? ~last_grant : OWN_DATA;
    end else if (data_req) begin
      gnt_owner = OWN_DATA;
    end else begin
      gnt_owner = OWN_INST;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates one downstream memory port between instruction fetch and data access,
// translating the granted virtual address through the fixed kseg map.
//   clk, resetn : clock, asynchronous active-low reset
//   inst        : fetch requester (read-only; wr/size/wdata ignored)
//   data        : data requester (read/write)
//   mem         : downstream port, physical address plus uncache flag
// One transaction in flight: IDLE -> ADDR -> DATA -> IDLE.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter bit          FAIR   = 1'b1,
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               resetn,
  mem_req_arbiter_if.slave  inst,
  mem_req_arbiter_if.slave  data,
  mem_req_arbiter_if.master mem
);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [BUS_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              uncache_q, uncache_d;

  logic   gnt_valid, gnt_owner;
  xlate_t xl;
  logic   addr_hit, data_hit;

  // Fetch-side write fields and requester-side uncache have no meaning here.
  logic unused_bus;
  assign unused_bus = ^{inst.wr, inst.size, inst.wdata, inst.uncache, data.uncache};

  arb_pick #(
    .FAIR(FAIR)
  ) u_arb_pick (
    .inst_req  (inst.req),
    .data_req  (data.req),
    .last_grant(last_grant_q),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  assign xl = xlate((gnt_owner == OWN_DATA) ? data.addr : inst.addr);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    uncache_d    = uncache_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d      = ST_ADDR;
          owner_d      = gnt_owner;
          last_grant_d = gnt_owner;
          addr_d       = xl.addr;
          uncache_d    = xl.uncache;
          if (gnt_owner == OWN_DATA) begin
            wr_d    = data.wr;
            size_d  = data.size;
            wdata_d = data.wdata;
          end else begin
            wr_d    = 1'b0;
            size_d  = SZ_W;
            wdata_d = '0;
          end
        end
      end
      ST_ADDR: if (mem.addr_ok) state_d = ST_DATA;
      ST_DATA: if (mem.data_ok) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      last_grant_q <= OWN_INST;
      wr_q         <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      uncache_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      uncache_q    <= uncache_d;
    end
  end

  // Downstream request fields come straight from registers so they stay stable under stalls.
  assign mem.req     = (state_q == ST_ADDR);
  assign mem.wr      = wr_q;
  assign mem.size    = size_q;
  assign mem.addr    = addr_q;
  assign mem.wdata   = wdata_q;
  assign mem.uncache = uncache_q;

  assign addr_hit = (state_q == ST_ADDR) && mem.addr_ok;
  assign data_hit = (state_q == ST_DATA) && mem.data_ok;

  assign inst.addr_ok = addr_hit && (owner_q == OWN_INST);
  assign data.addr_ok = addr_hit && (owner_q == OWN_DATA);
  assign inst.data_ok = data_hit && (owner_q == OWN_INST);
  assign data.data_ok = data_hit && (owner_q == OWN_DATA);
  assign inst.rdata   = (data_hit && (owner_q == OWN_INST)) ? mem.rdata : '0;
  assign data.rdata   = (data_hit && (owner_q == OWN_DATA)) ? mem.rdata : '0;

endmodule

// File: tb/tb_mem_req_arbiter.sv
`timescale 1ns/1ps
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_req_arbiter_if inst_if ();
  mem_req_arbiter_if data_if ();
  mem_req_arbiter_if mem_if ();
  mem_req_arbiter_if inst2_if ();
  mem_req_arbiter_if data2_if ();
  mem_req_arbiter_if mem2_if ();

  mem_req_arbiter #(.FAIR(1'b1), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .inst(inst_if), .data(data_if), .mem(mem_if)
  );

  mem_req_arbiter #(.FAIR(1'b0), .DATA_W(32)) dut_strict (
    .clk(clk), .resetn(resetn), .inst(inst2_if), .data(data2_if), .mem(mem2_if)
  );

  int errors = 0;
  int checks = 0;

  // Observations gathered by serve() for the main DUT.
  bit          obs_timeout, obs_stable, obs_req_in_data;
  int          obs_lat, obs_gnt;
  int          obs_aok_i, obs_aok_d, obs_dok_i, obs_dok_d;
  logic [31:0] obs_addr, obs_wdata, obs_rdata_i, obs_rdata_d;
  logic [1:0]  obs_size;
  logic        obs_wr, obs_unc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic init_inputs;
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = '0; inst_if.addr = '0;
    inst_if.wdata = '0; inst_if.uncache = 0;
    data_if.req = 0; data_if.wr = 0; data_if.size = '0; data_if.addr = '0;
    data_if.wdata = '0; data_if.uncache = 0;
    mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = '0;
    inst2_if.req = 0; inst2_if.wr = 0; inst2_if.size = '0; inst2_if.addr = '0;
    inst2_if.wdata = '0; inst2_if.uncache = 0;
    data2_if.req = 0; data2_if.wr = 0; data2_if.size = '0; data2_if.addr = '0;
    data2_if.wdata = '0; data2_if.uncache = 0;
    mem2_if.addr_ok = 0; mem2_if.data_ok = 0; mem2_if.rdata = '0;
  endtask

  task automatic apply_reset;
    resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  // Plays the downstream slave for one transaction: addr_ok after alat stall cycles,
  // data_ok after dlat stall cycles. Optionally drops the winner's req on its addr_ok.
  task automatic serve(input int alat, input int dlat, input logic [31:0] rd, input bit drop);
    int n;
    obs_timeout = 0; obs_stable = 1; obs_req_in_data = 0; obs_gnt = 2;
    obs_aok_i = 0; obs_aok_d = 0; obs_dok_i = 0; obs_dok_d = 0;
    obs_rdata_i = '0; obs_rdata_d = '0;
    n = 0;
    @(negedge clk);
    while (mem_if.req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    obs_lat = n;
    if (mem_if.req !== 1'b1) begin
      obs_timeout = 1;
      return;
    end
    obs_addr = mem_if.addr; obs_wdata = mem_if.wdata; obs_size = mem_if.size;
    obs_wr = mem_if.wr; obs_unc = mem_if.uncache;
    for (int i = 0; i < alat; i++) begin
      obs_aok_i += int'(inst_if.addr_ok); obs_aok_d += int'(data_if.addr_ok);
      @(negedge clk);
      if (mem_if.req !== 1'b1 || mem_if.addr !== obs_addr || mem_if.wdata !== obs_wdata ||
          mem_if.size !== obs_size || mem_if.wr !== obs_wr || mem_if.uncache !== obs_unc)
        obs_stable = 0;
    end
    mem_if.addr_ok = 1;
    #1;
    obs_aok_i += int'(inst_if.addr_ok); obs_aok_d += int'(data_if.addr_ok);
    if (inst_if.addr_ok === 1'b1 && data_if.addr_ok === 1'b0) obs_gnt = 0;
    else if (inst_if.addr_ok === 1'b0 && data_if.addr_ok === 1'b1) obs_gnt = 1;
    @(posedge clk);
    #1 mem_if.addr_ok = 0;
    if (drop) begin
      if (obs_gnt == 0) inst_if.req = 0;
      else if (obs_gnt == 1) data_if.req = 0;
    end
    for (int i = 0; i < dlat; i++) begin
      @(negedge clk);
      if (mem_if.req !== 1'b0) obs_req_in_data = 1;
      obs_dok_i += int'(inst_if.data_ok); obs_dok_d += int'(data_if.data_ok);
    end
    @(negedge clk);
    if (mem_if.req !== 1'b0) obs_req_in_data = 1;
    mem_if.data_ok = 1; mem_if.rdata = rd;
    #1;
    obs_dok_i += int'(inst_if.data_ok); obs_dok_d += int'(data_if.data_ok);
    obs_rdata_i = inst_if.rdata; obs_rdata_d = data_if.rdata;
    @(posedge clk);
    #1 mem_if.data_ok = 0; mem_if.rdata = '0;
  endtask

  task automatic test_reset;
    resetn = 0;
    inst_if.req = 1; data_if.req = 1; inst_if.addr = 32'hBFC00000;
    mem_if.addr_ok = 1; mem_if.data_ok = 1; mem_if.rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_if.req, mem_if.wr, mem_if.size, mem_if.addr, mem_if.wdata, mem_if.uncache} !== '0) begin
      errors++;
      $display("FAIL reset_mem_outputs: got req=%b wr=%b size=%0d addr=%h wdata=%h unc=%b want all 0",
               mem_if.req, mem_if.wr, mem_if.size, mem_if.addr, mem_if.wdata, mem_if.uncache);
    end
    checks++;
    if ({inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_acks: got %b want 0000",
               {inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok});
    end
    checks++;
    if ({inst_if.rdata, data_if.rdata} !== 64'd0) begin
      errors++;
      $display("FAIL reset_rdata: got inst=%h data=%h want 0", inst_if.rdata, data_if.rdata);
    end
    init_inputs();
    @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    checks++;
    if (mem_if.req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got mem_req=%b want 0", mem_if.req);
    end
  endtask

  task automatic test_fetch;
    @(posedge clk);
    #1 inst_if.req = 1; inst_if.addr = 32'hBFC00000; inst_if.wr = 1; inst_if.size = SZ_B;
    serve(0, 0, 32'h3C08BFC0, 1'b1);
    inst_if.wr = 0; inst_if.size = '0;
    checks++;
    if (obs_timeout || obs_lat != 1) begin
      errors++;
      $display("FAIL fetch_latency: got %0d cycles (timeout=%0d) want 1", obs_lat, obs_timeout);
    end
    checks++;
    if ({obs_addr, obs_unc, obs_wr, obs_size} !== {32'h1FC00000, 1'b1, 1'b0, SZ_W}) begin
      errors++;
      $display("FAIL fetch_fields: got addr=%h unc=%b wr=%b size=%0d want 1fc00000 1 0 2",
               obs_addr, obs_unc, obs_wr, obs_size);
    end
    checks++;
    if (obs_gnt != 0 || obs_aok_i != 1 || obs_dok_i != 1 || obs_aok_d != 0 || obs_dok_d != 0) begin
      errors++;
      $display("FAIL fetch_handshake: got gnt=%0d aok_i=%0d dok_i=%0d aok_d=%0d dok_d=%0d want 0 1 1 0 0",
               obs_gnt, obs_aok_i, obs_dok_i, obs_aok_d, obs_dok_d);
    end
    checks++;
    if (obs_rdata_i !== 32'h3C08BFC0 || obs_rdata_d !== 32'h0) begin
      errors++;
      $display("FAIL fetch_rdata: got inst=%h data=%h want 3c08bfc0 0", obs_rdata_i, obs_rdata_d);
    end
  endtask

  task automatic test_data_write;
    @(posedge clk);
    #1 data_if.req = 1; data_if.wr = 1; data_if.size = SZ_B;
    data_if.addr = 32'h80001004; data_if.wdata = 32'h000000AB;
    serve(0, 0, 32'hDEADBEEF, 1'b1);
    checks++;
    if ({obs_addr, obs_unc, obs_wr, obs_size, obs_wdata} !==
        {32'h00001004, 1'b0, 1'b1, SZ_B, 32'h000000AB}) begin
      errors++;
      $display("FAIL write_fields: got addr=%h unc=%b wr=%b size=%0d wdata=%h want 00001004 0 1 0 000000ab",
               obs_addr, obs_unc, obs_wr, obs_size, obs_wdata);
    end
    checks++;
    if (obs_gnt != 1 || obs_aok_d != 1 || obs_dok_d != 1) begin
      errors++;
      $display("FAIL write_handshake: got gnt=%0d aok_d=%0d dok_d=%0d want 1 1 1",
               obs_gnt, obs_aok_d, obs_dok_d);
    end
    checks++;
    if (obs_aok_i != 0 || obs_dok_i != 0 || obs_rdata_i !== 32'h0) begin
      errors++;
      $display("FAIL write_inst_quiet: got aok_i=%0d dok_i=%0d rdata_i=%h want 0 0 0",
               obs_aok_i, obs_dok_i, obs_rdata_i);
    end
    @(negedge clk);
    checks++;
    if (data_if.data_ok !== 1'b0 || mem_if.req !== 1'b0) begin
      errors++;
      $display("FAIL write_single_pulse: got data_ok=%b mem_req=%b want 0 0", data_if.data_ok, mem_if.req);
    end
    data_if.wr = 0; data_if.wdata = '0;
  endtask

  task automatic test_segments;
    logic [31:0] vaddr [3];
    logic [31:0] paddr [3];
    logic        unc   [3];
    vaddr[0] = 32'h00400000; paddr[0] = 32'h00400000; unc[0] = 1'b0;
    vaddr[1] = 32'hFF000000; paddr[1] = 32'hFF000000; unc[1] = 1'b0;
    vaddr[2] = 32'h9FC00040; paddr[2] = 32'h1FC00040; unc[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 data_if.req = 1; data_if.wr = 0; data_if.size = SZ_W; data_if.addr = vaddr[k];
      serve(1, 1, 32'h11223344 + k, 1'b1);
      checks++;
      if (obs_timeout || obs_addr !== paddr[k] || obs_unc !== unc[k]) begin
        errors++;
        $display("FAIL segment_%0d: got addr=%h unc=%b want %h %b", k, obs_addr, obs_unc,
                 paddr[k], unc[k]);
      end
    end
    checks++;
    if (obs_rdata_d !== 32'h11223346) begin
      errors++;
      $display("FAIL segment_rdata: got %h want 11223346", obs_rdata_d);
    end
  endtask

  task automatic test_fair;
    int exp_gnt [4];
    logic [31:0] exp_addr [4];
    exp_gnt[0] = 1; exp_gnt[1] = 0; exp_gnt[2] = 1; exp_gnt[3] = 0;
    exp_addr[0] = 32'h00000100; exp_addr[1] = 32'h00000200;
    exp_addr[2] = 32'h00000100; exp_addr[3] = 32'h00000200;
    apply_reset();
    inst_if.req = 1; inst_if.addr = 32'h80000200;
    data_if.req = 1; data_if.wr = 0; data_if.size = SZ_W; data_if.addr = 32'h80000100;
    for (int k = 0; k < 4; k++) begin
      serve(0, 0, 32'h0, 1'b0);
      checks++;
      if (obs_timeout || obs_gnt != exp_gnt[k] || obs_addr !== exp_addr[k]) begin
        errors++;
        $display("FAIL fair_grant_%0d: got owner=%0d addr=%h want %0d %h", k, obs_gnt, obs_addr,
                 exp_gnt[k], exp_addr[k]);
      end
    end
    inst_if.req = 0; data_if.req = 0;
  endtask

  task automatic test_strict;
    int n_i, n_d;
    apply_reset();
    inst2_if.req = 1; inst2_if.addr = 32'h80000000;
    data2_if.req = 1; data2_if.size = SZ_W; data2_if.addr = 32'h80000040;
    mem2_if.addr_ok = 1; mem2_if.data_ok = 1;
    n_i = 0; n_d = 0;
    repeat (12) begin
      @(negedge clk);
      n_i += int'(inst2_if.addr_ok); n_d += int'(data2_if.addr_ok);
    end
    checks++;
    if (n_d != 4 || n_i != 0) begin
      errors++;
      $display("FAIL strict_priority: got data_grants=%0d inst_grants=%0d want 4 0", n_d, n_i);
    end
    @(posedge clk);
    #1 data2_if.req = 0;
    n_i = 0;
    repeat (6) begin
      @(negedge clk);
      n_i += int'(inst2_if.addr_ok);
    end
    checks++;
    if (n_i != 2) begin
      errors++;
      $display("FAIL strict_inst_after_release: got inst_grants=%0d want 2", n_i);
    end
    @(posedge clk);
    #1 inst2_if.req = 0;
  endtask

  task automatic test_stall;
    @(posedge clk);
    #1 data_if.req = 1; data_if.wr = 1; data_if.size = SZ_H;
    data_if.addr = 32'hA0000020; data_if.wdata = 32'h00001234;
    serve(3, 5, 32'h0, 1'b1);
    checks++;
    if (obs_timeout || !obs_stable || obs_req_in_data) begin
      errors++;
      $display("FAIL stall_stable: got timeout=%0d stable=%0d req_in_data=%0d want 0 1 0",
               obs_timeout, obs_stable, obs_req_in_data);
    end
    checks++;
    if (obs_aok_d != 1 || obs_dok_d != 1 || obs_aok_i != 0 || obs_dok_i != 0) begin
      errors++;
      $display("FAIL stall_pulses: got aok_d=%0d dok_d=%0d aok_i=%0d dok_i=%0d want 1 1 0 0",
               obs_aok_d, obs_dok_d, obs_aok_i, obs_dok_i);
    end
    checks++;
    if ({obs_addr, obs_unc, obs_size, obs_wdata} !== {32'h00000020, 1'b1, SZ_H, 32'h00001234}) begin
      errors++;
      $display("FAIL stall_fields: got addr=%h unc=%b size=%0d wdata=%h want 00000020 1 1 00001234",
               obs_addr, obs_unc, obs_size, obs_wdata);
    end
    data_if.wr = 0; data_if.wdata = '0;
  endtask

  task automatic test_reset_mid;
    int late;
    @(posedge clk);
    #1 inst_if.req = 1; inst_if.addr = 32'hBFC00100;
    @(negedge clk);
    @(negedge clk);
    mem_if.addr_ok = 1;
    @(posedge clk);
    #1 mem_if.addr_ok = 0; inst_if.req = 0;
    @(negedge clk);
    checks++;
    if (mem_if.addr !== 32'h1FC00100 || mem_if.req !== 1'b0) begin
      errors++;
      $display("FAIL midreset_setup: got addr=%h req=%b want 1fc00100 0", mem_if.addr, mem_if.req);
    end
    #1 resetn = 0;
    #1;
    checks++;
    if ({mem_if.req, mem_if.wr, mem_if.size, mem_if.addr, mem_if.wdata, mem_if.uncache} !== '0) begin
      errors++;
      $display("FAIL midreset_async_clear: got addr=%h size=%0d unc=%b want 0 0 0",
               mem_if.addr, mem_if.size, mem_if.uncache);
    end
    mem_if.data_ok = 1; mem_if.rdata = 32'h55555555;
    late = 0;
    @(posedge clk);
    #1 resetn = 1;
    repeat (3) begin
      @(negedge clk);
      late += int'(inst_if.data_ok) + int'(data_if.data_ok);
    end
    checks++;
    if (late != 0 || inst_if.rdata !== 32'h0) begin
      errors++;
      $display("FAIL midreset_late_data_ok: got pulses=%0d rdata=%h want 0 0", late, inst_if.rdata);
    end
    @(posedge clk);
    #1 mem_if.data_ok = 0; mem_if.rdata = '0;
    inst_if.req = 1; inst_if.addr = 32'h00000300;
    data_if.req = 1; data_if.wr = 0; data_if.size = SZ_W; data_if.addr = 32'h00000400;
    serve(0, 0, 32'h0, 1'b1);
    inst_if.req = 0; data_if.req = 0;
    checks++;
    if (obs_timeout || obs_gnt != 1 || obs_addr !== 32'h00000400) begin
      errors++;
      $display("FAIL midreset_tie_to_data: got owner=%0d addr=%h want 1 00000400", obs_gnt, obs_addr);
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_fetch();
    test_data_write();
    test_segments();
    test_fair();
    test_strict();
    test_stall();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Arbitrates one downstream sram-like memory port between the instruction-fetch requester (read-only) and the data requester (read/write).
- Translates each granted virtual address to a physical address using the fixed kseg segment rules, and flags kseg1 accesses as uncached.
- Sits between the CPU pipeline and the cache/bus bridge.
- Allows one outstanding transaction at a time.

Parameters:
- FAIR, 1: 1 = alternate grants when both requesters are pending; 0 = strict data priority.
- DATA_W, 32: data bus width (only 32 is supported).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  32  fetch virtual address
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request; held with its fields until data_addr_ok
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data virtual address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  read data valid / write done
- data_rdata  out  32  data read data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write
- mem_size  out  2  downstream size
- mem_addr  out  32  physical address
- mem_wdata  out  32  downstream write data
- mem_uncache  out  1  1 = kseg1 access
- mem_addr_ok  in  1  downstream address accepted
- mem_data_ok  in  1  downstream data/ack
- mem_rdata  in  32  downstream read data

Behaviour:
- State machine: IDLE, ADDR, DATA. Registers: owner (INST/DATA), last_grant, and latched wr/size/addr/wdata/uncache.
- Reset: state = IDLE; owner = INST; last_grant = INST (the first tie goes to data). All mem_* outputs, all *_addr_ok, all *_data_ok and all rdata outputs are 0.
- An asynchronous reset mid-transaction aborts it. No data_ok is issued afterwards.
- IDLE, no request: remain in IDLE.
- IDLE, one request pending: grant it.
- IDLE, both pending: FAIR=1 grants the requester that is not last_grant; FAIR=0 grants data.
- On a grant: latch the fields (inst grants force wr = 0, size = 2), update owner and last_grant, and go to ADDR on the next edge.
- ADDR: mem_req = 1, driven only from registers.
- ADDR and mem_addr_ok = 1: the owner's *_addr_ok pulses high in the same cycle (combinational) and the state moves to DATA. Otherwise hold, with all latched outputs stable.
- DATA: mem_req = 0.
- DATA and mem_data_ok = 1: the owner's *_data_ok pulses in the same cycle; *_rdata = mem_rdata (combinational, valid only during that pulse); the state moves to IDLE.
- The non-owner's addr_ok and data_ok are always 0.
- mem_data_ok and mem_addr_ok are ignored outside DATA and ADDR respectively.
- Latency: req seen at cycle 0, mem_req at cycle 1, addr_ok in the same cycle as mem_addr_ok. There is at least one IDLE cycle between transactions.
- Address map on the latched address:
  - [31:29] = 100 (kseg0): clear bit 31, uncache = 0.
  - [31:29] = 101 (kseg1): clear bits 31:29, uncache = 1.
  - Otherwise (useg/ksseg/kseg3): pass through unchanged, uncache = 0.
- Alignment: data_addr alignment is not checked; misalignment exceptions are handled upstream.
- A requester that deasserts req before its addr_ok is a protocol violation. The latched transaction still completes.

Decomposition:
- Shared package:
  - state encodings IDLE = 0, ADDR = 1, DATA = 2.
  - owner encoding INST = 0, DATA = 1.
  - size constants SZ_B = 0, SZ_H = 1, SZ_W = 2.
  - segment prefix constants KSEG0 = 3'b100, KSEG1 = 3'b101.
- One sub-module: arb_pick, a combinational 2-way grant selector taking inst_req, data_req, last_grant and FAIR, and returning the grant.
- Address translation stays inline.

Test Plan:
1. Fetch only: inst_addr = 0xBFC00000 -> mem_addr = 0x1FC00000, mem_uncache = 1, mem_wr = 0, mem_size = 2. inst_addr_ok on mem_addr_ok; inst_data_ok with inst_rdata = 0x3C08BFC0.
2. Data write: data_addr = 0x80001004, size 0, wdata = 0xAB -> mem_addr = 0x00001004, mem_uncache = 0, mem_wr = 1, mem_size = 0. data_data_ok pulses once; inst_* outputs stay 0.
3. Both requesters held for 4 transactions, FAIR=1 -> grant order DATA, INST, DATA, INST. With FAIR=0 -> DATA, DATA, ... with inst starved while data_req is held.
4. Slave stalls: mem_addr_ok delayed 3 cycles, then mem_data_ok delayed 5 cycles -> mem_req/addr/wdata held stable throughout ADDR; exactly one addr_ok and one data_ok pulse.
5. useg address 0x00400000 -> passes through unchanged, mem_uncache = 0. kseg3 address 0xFF000000 -> passes through unchanged.
6. resetn asserted while in DATA -> outputs 0 immediately; a late mem_data_ok produces no requester data_ok; the next tie is granted to data.
